timed_event_dispatcher: RTL and testbench
=========================================

Name: timed_event_dispatcher

Overview:
- Consumer of the 64-bit free-running timestamp counter.
- Buffers (timestamp, data) events in a FIFO and releases each one when the counter reaches its timestamp.
- Sits between the host/sequencer command path and the output drivers (TTL/DDS update strobes).
- Flags events that arrive too late, and writes dropped because the FIFO is full.

Parameters:
- DATA_WIDTH, 64, width of the event payload.
- FIFO_DEPTH, 16, number of event entries; must be a power of 2.
- ADDR_WIDTH, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- counter  in  64  current timestamp from the timestamp counter, same clock domain.
- enable  in  1  dispatch enable; when low, events queue but never fire.
- flush  in  1  clears the FIFO; errors are untouched.
- in_valid  in  1  event write request.
- in_ready  out  1  equals !full.
- in_timestamp  in  64  event fire time.
- in_data  in  DATA_WIDTH  event payload.
- out_valid  out  1  one-cycle pulse per dispatched event.
- out_timestamp  out  64  timestamp of the dispatched event.
- out_data  out  DATA_WIDTH  payload of the dispatched event.
- late_error  out  1  sticky; an event was dispatched after its timestamp.
- overflow_error  out  1  sticky; a write was dropped because the FIFO was full.
- error_clear  in  1  clears both sticky errors.
- fifo_count  out  ADDR_WIDTH+1  number of entries held.
- empty  out  1  fifo_count == 0.
- full  out  1  fifo_count == FIFO_DEPTH.

Behaviour:
- Reset values: out_valid=0, out_timestamp=0, out_data=0, late_error=0, overflow_error=0, fifo_count=0, empty=1, full=0, in_ready=1. Pointers are set to 0.
- FIFO:
  - Circular buffer; read/write pointers are ADDR_WIDTH+1 bits so full and empty can be distinguished.
  - Push when in_valid && in_ready.
  - A written entry becomes head-visible one cycle after the write edge. An event written into an empty FIFO is first eligible on the next cycle.
- Dispatch condition, evaluated each cycle: enable && !empty && (head_ts <= counter), using an unsigned 64-bit compare. No wrap handling; the 64-bit counter does not wrap in practice.
- On a dispatch edge:
  - Pop the head.
  - Register out_timestamp and out_data from the head.
  - Drive out_valid=1 for exactly the following cycle. Latency is 1 cycle from the compare-true edge.
- Late detection: if head_ts < counter at dispatch, set late_error. This covers:
  - enable asserted after the time has passed;
  - an event written with a past timestamp;
  - multiple events sharing one timestamp — only the first fires on time; later ones fire on consecutive cycles and flag late.
- Throughput: at most one dispatch per cycle.
- out_timestamp and out_data hold their last value while out_valid=0.
- Simultaneous push and pop:
  - Allowed when not full; fifo_count is unchanged.
  - When full, in_ready=0 even if a pop occurs the same cycle; no pass-through.
- Overflow: in_valid && !in_ready sets overflow_error. The entry is dropped and FIFO state is unchanged.
- Flush:
  - Resets pointers and count in one cycle.
  - Overrides a same-cycle push or pop. No dispatch occurs that cycle and out_valid is 0 the next cycle.
  - A dispatch made the previous cycle still presents its out_valid pulse.
- error_clear:
  - Clears late_error and overflow_error.
  - If a set condition occurs in the same cycle, set wins.
- Priority order: reset > flush > {push, pop} > hold.
- enable deassertion: dispatch stops immediately; queued entries are retained.
- Reset mid-operation: FIFO contents are discarded, and any pending out_valid pulse is suppressed.

Test Plan:
- On-time dispatch: reset, counter starting at 100 and incrementing; push (ts=105, data=0xA5). Required: out_valid pulses once during the cycle after the counter=105 edge, with out_timestamp=105, out_data=0xA5, late_error=0, empty=1 afterwards.
- Ordering and equal timestamps: push ts=200, 200, 210 with data 1, 2, 3. Required:
  - data 1 is output when the counter is at 200;
  - data 2 is output one cycle later (counter 201) with late_error=1;
  - data 3 is output at counter 210.
- Late event: counter=500, push ts=300. Required: dispatch on the 2nd cycle after the write and late_error=1. error_clear then takes late_error back to 0.
- Full/overflow: enable=0, push 17 events. Required:
  - fifo_count=16 with full=1 and in_ready=0;
  - the 17th write sets overflow_error and fifo_count stays 16;
  - after enable=1, all 16 events dispatch in timestamp order.
- Flush vs push: with 5 entries queued, assert flush and in_valid in the same cycle. Required: fifo_count=0 and empty=1 on the next cycle, and no out_valid pulse follows.
- Reset mid-operation: with 3 entries queued and a dispatch just issued, assert reset. Required: all outputs at reset values on the next cycle and no out_valid pulse.

Source files
------------

// File: rtl/timed_event_dispatcher.sv
// Timestamp-scheduled event FIFO: queues (timestamp, payload) pairs and releases the
// head when the shared 64-bit counter reaches its timestamp, flagging late and dropped events.
module timed_event_dispatcher #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           counter,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_timestamp,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [63:0]           out_timestamp,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  late_error,
  output logic                  overflow_error,
  input  logic                  error_clear,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  empty,
  output logic                  full
);

  logic [63:0]           ts_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [63:0]           out_ts_q, out_ts_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  late_q, late_d;
  logic                  ovf_q, ovf_d;

  logic [ADDR_WIDTH:0]   count;
  logic [63:0]           head_ts;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  push, pop;

  // Pointers carry one extra wrap bit so a full FIFO is distinguishable from an empty one.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == (ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign head_ts   = ts_mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign head_data = data_mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  // Flush takes precedence over both queue operations for the cycle.
  assign push = in_valid && !full && !flush;
  assign pop  = enable && !empty && (head_ts <= counter) && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = pop;
    out_ts_d    = out_ts_q;
    out_data_d  = out_data_q;
    late_d      = late_q;
    ovf_d       = ovf_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
    end

    if (pop) begin
      out_ts_d   = head_ts;
      out_data_d = head_data;
    end

    // A same-cycle set beats error_clear.
    if (error_clear) begin
      late_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (pop && (head_ts < counter)) late_d = 1'b1;
    if (in_valid && full)           ovf_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ts_q    <= '0;
      out_data_q  <= '0;
      late_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_ts_q    <= out_ts_d;
      out_data_q  <= out_data_d;
      late_q      <= late_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem_q[wr_ptr_q[ADDR_WIDTH-1:0]]   <= in_timestamp;
      data_mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_timestamp  = out_ts_q;
  assign out_data       = out_data_q;
  assign late_error     = late_q;
  assign overflow_error = ovf_q;
  assign fifo_count     = count;

endmodule

// File: tb/tb_timed_event_dispatcher.sv
// Directed bench for timed_event_dispatcher: per-cycle vector table plus
// hand sequences for full/overflow, flush and mid-operation reset.
module tb_timed_event_dispatcher;

  localparam int DW = 64;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   counter = '0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_timestamp = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [63:0]   out_timestamp;
  logic [DW-1:0] out_data;
  logic          late_error;
  logic          overflow_error;
  logic          error_clear = 1'b0;
  logic [AW:0]   fifo_count;
  logic          empty;
  logic          full;

  int total = 0;
  int bad = 0;

  timed_event_dispatcher #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .counter(counter), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_timestamp(in_timestamp), .in_data(in_data),
    .out_valid(out_valid), .out_timestamp(out_timestamp), .out_data(out_data),
    .late_error(late_error), .overflow_error(overflow_error), .error_clear(error_clear),
    .fifo_count(fifo_count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cnt;
    logic        en;
    logic        vld;
    logic [63:0] ts;
    logic [63:0] data;
    logic        clr;
    logic        exp_ov;
    logic [63:0] exp_ts;
    logic [63:0] exp_data;
    logic        exp_late;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [63:0] cnt, logic en, logic vld, logic [63:0] ts,
                              logic [63:0] data, logic clr, logic exp_ov, logic [63:0] exp_ts,
                              logic [63:0] exp_data, logic exp_late, int exp_cnt);
    vec_t v;
    v.cnt = cnt; v.en = en; v.vld = vld; v.ts = ts; v.data = data; v.clr = clr;
    v.exp_ov = exp_ov; v.exp_ts = exp_ts; v.exp_data = exp_data;
    v.exp_late = exp_late; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; error_clear = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_ev(input logic [63:0] ts, input logic [63:0] d);
    in_valid = 1'b1; in_timestamp = ts; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Table: inputs for one cycle, expected outputs after that cycle's edge.
    vecs.push_back(mk(100, 1, 1, 105, 'hA5, 0, 0,   0,    0, 0, 1));
    vecs.push_back(mk(101, 1, 0,   0,    0, 0, 0,   0,    0, 0, 1));
    vecs.push_back(mk(102, 1, 0,   0,    0, 0, 0,   0,    0, 0, 1));
    vecs.push_back(mk(103, 1, 0,   0,    0, 0, 0,   0,    0, 0, 1));
    vecs.push_back(mk(104, 1, 0,   0,    0, 0, 0,   0,    0, 0, 1));
    vecs.push_back(mk(105, 1, 0,   0,    0, 0, 1, 105, 'hA5, 0, 0));
    vecs.push_back(mk(106, 1, 0,   0,    0, 0, 0, 105, 'hA5, 0, 0));
    vecs.push_back(mk(150, 1, 1, 200,    1, 0, 0, 105, 'hA5, 0, 1));
    vecs.push_back(mk(151, 1, 1, 200,    2, 0, 0, 105, 'hA5, 0, 2));
    vecs.push_back(mk(152, 1, 1, 210,    3, 0, 0, 105, 'hA5, 0, 3));
    vecs.push_back(mk(199, 1, 0,   0,    0, 0, 0, 105, 'hA5, 0, 3));
    vecs.push_back(mk(200, 1, 0,   0,    0, 0, 1, 200,    1, 0, 2));
    vecs.push_back(mk(201, 1, 0,   0,    0, 0, 1, 200,    2, 1, 1));
    vecs.push_back(mk(202, 1, 0,   0,    0, 0, 0, 200,    2, 1, 1));
    vecs.push_back(mk(209, 1, 0,   0,    0, 0, 0, 200,    2, 1, 1));
    vecs.push_back(mk(210, 1, 0,   0,    0, 0, 1, 210,    3, 1, 0));
    vecs.push_back(mk(211, 1, 0,   0,    0, 1, 0, 210,    3, 0, 0));
    vecs.push_back(mk(500, 1, 1, 300, 'h77, 0, 0, 210,    3, 0, 1));
    vecs.push_back(mk(501, 1, 0,   0,    0, 0, 1, 300, 'h77, 1, 0));
    vecs.push_back(mk(502, 1, 0,   0,    0, 1, 0, 300, 'h77, 0, 0));
    vecs.push_back(mk(600, 0, 1, 600, 'h11, 0, 0, 300, 'h77, 0, 1));
    vecs.push_back(mk(601, 0, 0,   0,    0, 0, 0, 300, 'h77, 0, 1));
    vecs.push_back(mk(602, 1, 0,   0,    0, 0, 1, 600, 'h11, 1, 0));
    vecs.push_back(mk(603, 1, 0,   0,    0, 1, 0, 600, 'h11, 0, 0));
    vecs.push_back(mk(700, 1, 1, 700, 'h21, 0, 0, 600, 'h11, 0, 1));
    vecs.push_back(mk(701, 1, 1, 800, 'h22, 0, 1, 700, 'h21, 1, 1));
    vecs.push_back(mk(702, 1, 0,   0,    0, 1, 0, 700, 'h21, 0, 1));

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ts", out_timestamp, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_late", late_error, 0);
    chk("rst_ovf", overflow_error, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      counter = vecs[i].cnt; enable = vecs[i].en; in_valid = vecs[i].vld;
      in_timestamp = vecs[i].ts; in_data = vecs[i].data; error_clear = vecs[i].clr;
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      chk($sformatf("v%0d_out_ts", i), out_timestamp, vecs[i].exp_ts);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("v%0d_late", i), late_error, vecs[i].exp_late);
      chk($sformatf("v%0d_ovf", i), overflow_error, 0);
      chk($sformatf("v%0d_count", i), fifo_count, vecs[i].exp_cnt);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].exp_cnt == 0);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0; error_clear = 1'b0;

    // Full / overflow: 17 writes with dispatch disabled, then drain in order.
    do_reset();
    counter = 1000;
    for (int i = 0; i < 17; i++) push_ev(64'd1100 + 64'(i), 64'(i));
    chk("ovf_count", fifo_count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_flag", overflow_error, 1);
    chk("ovf_out_valid", out_valid, 0);
    counter = 2000; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d_ts", i), out_timestamp, 64'd1100 + 64'(i));
      chk($sformatf("drain%0d_data", i), out_data, 64'(i));
    end
    tick();
    chk("drain_end_valid", out_valid, 0);
    chk("drain_end_empty", empty, 1);
    chk("drain_late", late_error, 1);
    chk("drain_ovf_kept", overflow_error, 1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("clr_ovf", overflow_error, 0);
    chk("clr_late", late_error, 0);

    // Flush beats a same-cycle push and an eligible pop.
    do_reset();
    counter = 3000;
    for (int i = 0; i < 5; i++) push_ev(64'd2000 + 64'(i), 64'h50 + 64'(i));
    chk("fl_pre_count", fifo_count, 5);
    enable = 1'b1; flush = 1'b1; in_valid = 1'b1; in_timestamp = 64'd2500; in_data = 64'hEE;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", fifo_count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_out_valid", out_valid, 0);
    tick();
    chk("fl_out_valid2", out_valid, 0);
    chk("fl_count2", fifo_count, 0);

    // Reset with entries queued and a dispatch just issued.
    do_reset();
    counter = 3000;
    for (int i = 0; i < 4; i++) push_ev(64'd2900 + 64'(i), 64'h60 + 64'(i));
    enable = 1'b1;
    tick();
    chk("rm_issue_valid", out_valid, 1);
    chk("rm_issue_data", out_data, 64'h60);
    chk("rm_issue_count", fifo_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_out_valid", out_valid, 0);
    chk("rm_out_ts", out_timestamp, 0);
    chk("rm_out_data", out_data, 0);
    chk("rm_late", late_error, 0);
    chk("rm_count", fifo_count, 0);
    chk("rm_empty", empty, 1);
    chk("rm_in_ready", in_ready, 1);
    tick();
    chk("rm_out_valid2", out_valid, 0);
    chk("rm_count2", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
